// File: rtl/mmu_sequencer.sv
// Sequencer for a weight-stationary systolic MMU: streams weights, then input vectors,
// drains the array and writes one result row per input vector to the accumulator.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for START; job parameters latched on acceptance
// ST_LOAD_W  | one weight-buffer read per unstalled cycle, SA_LENGTH in total
// ST_COMPUTE | one input-buffer read per unstalled cycle, NUM_VECTORS in total
// ST_DRAIN   | array clocked with zero inputs until the result pipeline empties
// ST_FINISH  | single-cycle DONE pulse, then back to ST_IDLE
module mmu_sequencer #(
   parameter int SA_LENGTH      = 256,
   parameter int ADDR_WIDTH     = 16,
   parameter int RESULT_LATENCY = 2*SA_LENGTH
) (
   input  logic                  i_clk,
   input  logic                  i_sync_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_num_vectors,
   input  logic [ADDR_WIDTH-1:0] i_weight_base,
   input  logic [ADDR_WIDTH-1:0] i_input_base,
   input  logic [ADDR_WIDTH-1:0] i_result_base,
   input  logic                  i_stall,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_mmu_en,
   output logic                  o_mmu_load,
   output logic                  o_input_zero,
   output logic                  o_wbuf_rd_en,
   output logic [ADDR_WIDTH-1:0] o_wbuf_rd_addr,
   output logic                  o_ibuf_rd_en,
   output logic [ADDR_WIDTH-1:0] o_ibuf_rd_addr,
   output logic                  o_acc_wr_en,
   output logic [ADDR_WIDTH-1:0] o_acc_wr_addr
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_COMPUTE,
      ST_DRAIN,
      ST_FINISH
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_num;
   logic [ADDR_WIDTH-1:0]   r_left;
   logic [ADDR_WIDTH-1:0]   r_waddr;
   logic [ADDR_WIDTH-1:0]   r_iaddr;
   logic [ADDR_WIDTH-1:0]   r_aaddr;
   logic                    r_en_d;
   logic                    r_load_d;
   logic                    r_in_d;
   logic [RESULT_LATENCY-1:0] r_valid_sr;

   logic w_wissue;
   logic w_iissue;
   logic w_mmu_en;
   logic w_acc_wr;
   logic w_drain_empty;

   assign w_wissue = (r_state == ST_LOAD_W) && !i_stall;
   assign w_iissue = (r_state == ST_COMPUTE) && !i_stall;
   assign w_mmu_en = (r_en_d || (r_state == ST_DRAIN)) && !i_stall;
   assign w_acc_wr = r_valid_sr[RESULT_LATENCY-1] && !i_stall;

   // Empty once the row now at the tail leaves and nothing is still in flight behind it.
   assign w_drain_empty = (r_valid_sr[RESULT_LATENCY-2:0] == '0) && !r_in_d && !r_load_d;

   assign o_busy         = (r_state != ST_IDLE);
   assign o_done         = (r_state == ST_FINISH);
   assign o_input_zero   = (r_state == ST_DRAIN);
   assign o_mmu_en       = w_mmu_en;
   assign o_mmu_load     = r_load_d;
   assign o_wbuf_rd_en   = w_wissue;
   assign o_wbuf_rd_addr = w_wissue ? r_waddr : '0;
   assign o_ibuf_rd_en   = w_iissue;
   assign o_ibuf_rd_addr = w_iissue ? r_iaddr : '0;
   assign o_acc_wr_en    = w_acc_wr;
   assign o_acc_wr_addr  = w_acc_wr ? r_aaddr : '0;

   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         r_state    <= ST_IDLE;
         r_num      <= '0;
         r_left     <= '0;
         r_waddr    <= '0;
         r_iaddr    <= '0;
         r_aaddr    <= '0;
         r_en_d     <= 1'b0;
         r_load_d   <= 1'b0;
         r_in_d     <= 1'b0;
         r_valid_sr <= '0;
      end else if (r_state == ST_FINISH) begin
         // DONE is never held or repeated by STALL.
         r_state <= ST_IDLE;
      end else if (!i_stall) begin
         r_en_d   <= w_wissue || w_iissue;
         r_load_d <= w_wissue;
         r_in_d   <= w_iissue;
         if (w_mmu_en)
            r_valid_sr <= {r_valid_sr[RESULT_LATENCY-2:0], r_in_d};
         if (w_acc_wr)
            r_aaddr <= r_aaddr + 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_num      <= i_num_vectors;
                  r_waddr    <= i_weight_base;
                  r_iaddr    <= i_input_base;
                  r_aaddr    <= i_result_base;
                  r_left     <= ADDR_WIDTH'(SA_LENGTH - 1);
                  r_valid_sr <= '0;
                  r_state    <= ST_LOAD_W;
               end
            end
            ST_LOAD_W: begin
               r_waddr <= r_waddr + 1'b1;
               if (r_left == '0) begin
                  if (r_num != '0) begin
                     r_left  <= r_num - 1'b1;
                     r_state <= ST_COMPUTE;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end else begin
                  r_left <= r_left - 1'b1;
               end
            end
            ST_COMPUTE: begin
               r_iaddr <= r_iaddr + 1'b1;
               if (r_left == '0)
                  r_state <= ST_DRAIN;
               else
                  r_left <= r_left - 1'b1;
            end
            ST_DRAIN: begin
               if (w_drain_empty)
                  r_state <= ST_FINISH;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Bench for mmu_sequencer (SA_LENGTH=4, RESULT_LATENCY=8): a progress-count model checked
// every cycle, plus literal event-timing expectations for each directed job.
module tb_mmu_sequencer;
   localparam int S  = 4;
   localparam int AW = 16;
   localparam int L  = 8;

   logic          clk = 1'b0;
   logic          i_sync_rst, i_start, i_stall;
   logic [AW-1:0] i_num_vectors, i_weight_base, i_input_base, i_result_base;
   logic          o_busy, o_done, o_mmu_en, o_mmu_load, o_input_zero;
   logic          o_wbuf_rd_en, o_ibuf_rd_en, o_acc_wr_en;
   logic [AW-1:0] o_wbuf_rd_addr, o_ibuf_rd_addr, o_acc_wr_addr;

   mmu_sequencer #(.SA_LENGTH(S), .ADDR_WIDTH(AW), .RESULT_LATENCY(L)) dut (
      .i_clk(clk), .i_sync_rst(i_sync_rst), .i_start(i_start),
      .i_num_vectors(i_num_vectors), .i_weight_base(i_weight_base),
      .i_input_base(i_input_base), .i_result_base(i_result_base), .i_stall(i_stall),
      .o_busy(o_busy), .o_done(o_done), .o_mmu_en(o_mmu_en), .o_mmu_load(o_mmu_load),
      .o_input_zero(o_input_zero), .o_wbuf_rd_en(o_wbuf_rd_en), .o_wbuf_rd_addr(o_wbuf_rd_addr),
      .o_ibuf_rd_en(o_ibuf_rd_en), .o_ibuf_rd_addr(o_ibuf_rd_addr),
      .o_acc_wr_en(o_acc_wr_en), .o_acc_wr_addr(o_acc_wr_addr));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int start_edge = 0;
   int cur_rel = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cur_rel);
      end
   endtask

   // Model: a job is an ordered list of unstalled steps; p counts steps completed so far.
   bit            m_job = 1'b0;
   int            m_p, m_nv, m_t;
   logic [AW-1:0] m_wb, m_ib, m_rb;

   // Event log for the literal expectations.
   int            done_cnt, done_rel, wbuf_cnt, ibuf_cnt, acc_cnt;
   int            first_ibuf_rel, first_acc_rel, first_load_rel, last_load_rel;
   logic [AW-1:0] acc_q[$];

   always @(negedge clk) begin
      if (cyc >= 1) begin
         logic          s, e_w, e_i, e_a, e_en, e_ld, e_z, e_busy, e_done;
         logic [AW-1:0] e_wa, e_ia, e_aa;
         cur_rel = cyc + 1 - start_edge;
         s      = i_stall;
         e_w    = m_job && !s && (m_p < S);
         e_i    = m_job && !s && (m_p >= S) && (m_p < S + m_nv);
         e_a    = m_job && !s && (m_p >= S + L + 1) && (m_p < S + L + 1 + m_nv);
         e_en   = m_job && !s && (m_p >= 1) && (m_p < m_t);
         e_ld   = m_job && (m_p >= 1) && (m_p <= S);
         e_z    = m_job && (m_p >= S + m_nv) && (m_p < m_t);
         e_busy = m_job;
         e_done = m_job && (m_p == m_t);
         e_wa   = e_w ? AW'(m_wb + AW'(m_p)) : '0;
         e_ia   = e_i ? AW'(m_ib + AW'(m_p - S)) : '0;
         e_aa   = e_a ? AW'(m_rb + AW'(m_p - (S + L + 1))) : '0;

         chk("busy",       32'(o_busy),         32'(e_busy));
         chk("done",       32'(o_done),         32'(e_done));
         chk("mmu_en",     32'(o_mmu_en),       32'(e_en));
         chk("mmu_load",   32'(o_mmu_load),     32'(e_ld));
         chk("input_zero", 32'(o_input_zero),   32'(e_z));
         chk("wbuf_rd_en", 32'(o_wbuf_rd_en),   32'(e_w));
         chk("wbuf_addr",  32'(o_wbuf_rd_addr), 32'(e_wa));
         chk("ibuf_rd_en", 32'(o_ibuf_rd_en),   32'(e_i));
         chk("ibuf_addr",  32'(o_ibuf_rd_addr), 32'(e_ia));
         chk("acc_wr_en",  32'(o_acc_wr_en),    32'(e_a));
         chk("acc_addr",   32'(o_acc_wr_addr),  32'(e_aa));

         if (o_done) begin done_cnt++; done_rel = cur_rel; end
         if (o_wbuf_rd_en) wbuf_cnt++;
         if (o_ibuf_rd_en) begin
            if (ibuf_cnt == 0) first_ibuf_rel = cur_rel;
            ibuf_cnt++;
         end
         if (o_acc_wr_en) begin
            if (acc_cnt == 0) first_acc_rel = cur_rel;
            acc_cnt++;
            acc_q.push_back(o_acc_wr_addr);
         end
         if (o_mmu_load) begin
            if (first_load_rel < 0) first_load_rel = cur_rel;
            last_load_rel = cur_rel;
         end

         if (i_sync_rst) begin
            m_job = 1'b0;
         end else if (m_job) begin
            if (m_p == m_t) m_job = 1'b0;
            else if (!i_stall) m_p++;
         end else if (i_start && !i_stall) begin
            m_job = 1'b1;
            m_p   = 0;
            m_nv  = int'(i_num_vectors);
            m_wb  = i_weight_base;
            m_ib  = i_input_base;
            m_rb  = i_result_base;
            m_t   = (m_nv > 0) ? (S + L + 1 + m_nv) : (S + 2);
         end
      end
   end

   task automatic start_job(input int nv, input int wb, input int ib, input int rb);
      @(posedge clk); #1;
      start_edge     = cyc + 1;
      i_start        = 1'b1;
      i_num_vectors  = AW'(nv);
      i_weight_base  = AW'(wb);
      i_input_base   = AW'(ib);
      i_result_base  = AW'(rb);
      done_cnt = 0; done_rel = -1; wbuf_cnt = 0; ibuf_cnt = 0; acc_cnt = 0;
      first_ibuf_rel = -1; first_acc_rel = -1; first_load_rel = -1; last_load_rel = -1;
      acc_q.delete();
   endtask

   task automatic run_cycles(input int n, input int st_lo, input int st_hi,
                             input int start_rel, input int rst_rel);
      for (int k = 0; k < n; k++) begin
         int r;
         @(posedge clk); #1;
         r          = cyc + 1 - start_edge;
         i_stall    = (r >= st_lo) && (r <= st_hi);
         i_start    = (r == start_rel);
         i_sync_rst = (r == rst_rel);
      end
      i_stall = 1'b0; i_start = 1'b0; i_sync_rst = 1'b0;
   endtask

   initial begin
      i_sync_rst = 1'b1; i_start = 1'b0; i_stall = 1'b0;
      i_num_vectors = '0; i_weight_base = '0; i_input_base = '0; i_result_base = '0;
      repeat (3) @(posedge clk);
      #1 i_sync_rst = 1'b0;
      @(posedge clk); #1;
      cur_rel = 0;
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_done", 32'(o_done), 32'd0);

      // Basic job.
      start_job(3, 'h10, 'h20, 'h40);
      run_cycles(22, -1, -1, -1, -1);
      chk("t1_done_cnt",   32'(done_cnt), 32'd1);
      chk("t1_done_rel",   32'(done_rel), 32'd17);
      chk("t1_wbuf_cnt",   32'(wbuf_cnt), 32'd4);
      chk("t1_load_first", 32'(first_load_rel), 32'd2);
      chk("t1_load_last",  32'(last_load_rel),  32'd5);
      chk("t1_ibuf_first", 32'(first_ibuf_rel), 32'd5);
      chk("t1_acc_first",  32'(first_acc_rel),  32'd14);
      chk("t1_acc_cnt",    32'(acc_cnt), 32'd3);
      chk("t1_acc_a0",     32'(acc_q[0]), 32'h40);
      chk("t1_acc_a2",     32'(acc_q[2]), 32'h42);

      // Stall in cycles 6-7 shifts later events by 2.
      start_job(3, 'h10, 'h20, 'h40);
      run_cycles(24, 6, 7, -1, -1);
      chk("t2_done_rel",  32'(done_rel), 32'd19);
      chk("t2_acc_first", 32'(first_acc_rel), 32'd16);
      chk("t2_acc_cnt",   32'(acc_cnt), 32'd3);

      // Zero vectors.
      start_job(0, 'h80, 'h90, 'hA0);
      run_cycles(12, -1, -1, -1, -1);
      chk("t3_wbuf_cnt", 32'(wbuf_cnt), 32'd4);
      chk("t3_ibuf_cnt", 32'(ibuf_cnt), 32'd0);
      chk("t3_acc_cnt",  32'(acc_cnt), 32'd0);
      chk("t3_done_cnt", 32'(done_cnt), 32'd1);
      chk("t3_busy_end", 32'(o_busy), 32'd0);

      // Second START mid-job is ignored.
      start_job(3, 'h10, 'h20, 'h40);
      run_cycles(22, -1, -1, 8, -1);
      chk("t4_acc_cnt",  32'(acc_cnt), 32'd3);
      chk("t4_done_cnt", 32'(done_cnt), 32'd1);

      // Reset mid-job aborts, then a fresh job completes.
      start_job(3, 'h10, 'h20, 'h40);
      run_cycles(14, -1, -1, -1, 10);
      chk("t5_done_cnt", 32'(done_cnt), 32'd0);
      start_job(3, 'h10, 'h20, 'h40);
      run_cycles(22, -1, -1, -1, -1);
      chk("t5_fresh_done_rel", 32'(done_rel), 32'd17);
      chk("t5_fresh_acc_cnt",  32'(acc_cnt), 32'd3);

      // Result address wraps.
      start_job(2, 'h0, 'h100, 'hFFFF);
      run_cycles(22, -1, -1, -1, -1);
      chk("t6_acc_cnt", 32'(acc_cnt), 32'd2);
      chk("t6_acc_a0",  32'(acc_q[0]), 32'hFFFF);
      chk("t6_acc_a1",  32'(acc_q[1]), 32'h0000);
      chk("t6_done_cnt", 32'(done_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
